// File: rtl/line_assembler.sv
// Line assembler: collects image/template pixel columns into a registered line.
// Define LINE_ASM_PAD_EN to add line_end for short, zero-padded lines.
module line_assembler #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 16,
    parameter int NUM_TEMPLATES = 4
) (
    input  logic                                                   CLK,
    input  logic                                                   RST_N,
    input  logic                                                   pix_valid,
    output logic                                                   pix_ready,
    input  logic [PIXEL_SIZE-1:0]                                  I_pix,
    input  logic [NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0]               T_pix,
`ifdef LINE_ASM_PAD_EN
    input  logic                                                   line_end,
`endif
    output logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                   I_out_line,
    output logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0] T_out_line,
    output logic                                                   line_valid,
    input  logic                                                   line_ready,
    output logic [15:0]                                            line_cnt
);

    localparam int PW = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t          state;
    state_t          state_n;
    logic [PW-1:0]   wr_ptr;
    logic [15:0]     cnt_q;
    logic            started;
    logic            accept;
    logic            handoff;
    logic            last_col;
    logic            close_line;

    assign last_col = (wr_ptr == PW'(LINE_SIZE - 1));
`ifdef LINE_ASM_PAD_EN
    assign close_line = last_col | line_end;
`else
    assign close_line = last_col;
`endif
    assign line_cnt = cnt_q;

    always_comb begin
        state_n    = state;
        pix_ready  = 1'b0;
        line_valid = 1'b0;
        accept     = 1'b0;
        handoff    = 1'b0;
        unique case (state)
            FILL: begin
                // started keeps pix_ready low until the first edge after reset
                pix_ready = started;
                accept    = pix_valid & started;
                if (accept && close_line) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                line_valid = 1'b1;
                handoff    = line_ready;
                if (line_ready) begin
                    state_n = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= FILL;
            started <= 1'b0;
            wr_ptr  <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            started <= 1'b1;
            if (accept) begin
                wr_ptr <= close_line ? '0 : wr_ptr + PW'(1);
            end
            if (handoff) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            I_out_line <= '0;
            T_out_line <= '0;
        end else if (accept) begin
            for (int i = 0; i < LINE_SIZE; i++) begin
                if (PW'(i) == wr_ptr) begin
                    I_out_line[i] <= I_pix;
                    T_out_line[i] <= T_pix;
                end
`ifdef LINE_ASM_PAD_EN
                // a short line clears every slot above its last column
                else if (line_end && (PW'(i) > wr_ptr)) begin
                    I_out_line[i] <= '0;
                    T_out_line[i] <= '0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_line_assembler.sv
// Directed self-checking bench for line_assembler.
// Covers fill, hold, handoff, gapped input, reset, count wrap and padding.
module tb_line_assembler;

    localparam int PS = 8;
    localparam int LS = 16;
    localparam int NT = 4;

    logic                        CLK = 1'b0;
    logic                        RST_N;
    logic                        pix_valid;
    logic                        pix_ready;
    logic [PS-1:0]               I_pix;
    logic [NT-1:0][PS-1:0]       T_pix;
`ifdef LINE_ASM_PAD_EN
    logic                        line_end;
`endif
    logic [LS-1:0][PS-1:0]       I_out_line;
    logic [LS-1:0][NT-1:0][PS-1:0] T_out_line;
    logic                        line_valid;
    logic                        line_ready;
    logic [15:0]                 line_cnt;

    logic [LS-1:0][PS-1:0]       exp_i;
    logic [LS-1:0][NT-1:0][PS-1:0] exp_t;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    line_assembler #(
        .PIXEL_SIZE(PS),
        .LINE_SIZE(LS),
        .NUM_TEMPLATES(NT)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .I_pix(I_pix),
        .T_pix(T_pix),
`ifdef LINE_ASM_PAD_EN
        .line_end(line_end),
`endif
        .I_out_line(I_out_line),
        .T_out_line(T_out_line),
        .line_valid(line_valid),
        .line_ready(line_ready),
        .line_cnt(line_cnt)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_col(input logic [PS-1:0] v);
        I_pix = v;
        for (int t = 0; t < NT; t++) T_pix[t] = v + 8'(16 * t);
    endtask

    task automatic note_col(input int k, input logic [PS-1:0] v);
        exp_i[k] = v;
        for (int t = 0; t < NT; t++) exp_t[k][t] = v + 8'(16 * t);
    endtask

    // offer one column and wait (bounded) until it is taken
    task automatic push_col(input int k, input logic [PS-1:0] v);
        int n;
        n = 0;
        set_col(v);
        pix_valid = 1'b1;
        while (!pix_ready && n < 50) begin
            tick();
            n++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: col %0d never accepted", k);
        end else begin
            tick();
            note_col(k, v);
        end
        pix_valid = 1'b0;
    endtask

    task automatic fill_line(input logic [PS-1:0] base);
        for (int k = 0; k < LS; k++) push_col(k, base + 8'(k));
    endtask

    task automatic do_handoff();
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        pix_valid = 1'b0;
        line_ready = 1'b0;
        set_col('0);
        exp_i = '0;
        exp_t = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_pix_ready: got %b expected 0", pix_ready);
        end
        checks++;
        if (line_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_line_valid: got %b expected 0", line_valid);
        end
        checks++;
        if (line_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL rst_line_cnt: got %h expected 0000", line_cnt);
        end
        checks++;
        if (I_out_line !== '0 || T_out_line !== '0) begin
            errors++;
            $display("FAIL rst_lines: got I=%h T=%h expected 0", I_out_line, T_out_line);
        end
        RST_N = 1'b1;
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_early: got %b expected 0", pix_ready);
        end
        tick();
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready_rise: got %b expected 1", pix_ready);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < LS; k++) begin
            push_col(k, 8'(k));
            if (k == LS - 2) begin
                checks++;
                if (line_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_early_valid: got %b expected 0", line_valid);
                end
            end
        end
        checks++;
        if (line_valid !== 1'b1 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_latency: got valid=%b ready=%b expected 1/0",
                     line_valid, pix_ready);
        end
        checks++;
        if (I_out_line !== exp_i) begin
            errors++;
            $display("FAIL fill_i_line: got %h expected %h", I_out_line, exp_i);
        end
        checks++;
        if (T_out_line !== exp_t) begin
            errors++;
            $display("FAIL fill_t_line: got %h expected %h", T_out_line, exp_t);
        end
        set_col(8'hFF);
        pix_valid = 1'b1;
        repeat (3) tick();
        pix_valid = 1'b0;
        checks++;
        if (I_out_line !== exp_i || T_out_line !== exp_t) begin
            errors++;
            $display("FAIL hold_stable: got I=%h expected %h", I_out_line, exp_i);
        end
        checks++;
        if (line_valid !== 1'b1 || line_cnt !== 16'd0) begin
            errors++;
            $display("FAIL hold_state: got valid=%b cnt=%h expected 1/0000",
                     line_valid, line_cnt);
        end
    endtask

    task automatic test_handoff();
        set_col(8'hA0);
        pix_valid = 1'b1;
        line_ready = 1'b1;
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL handoff_ready: got %b expected 0", pix_ready);
        end
        tick();
        line_ready = 1'b0;
        checks++;
        if (line_cnt !== 16'd1 || line_valid !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL handoff_fill: got cnt=%h valid=%b ready=%b expected 0001/0/1",
                     line_cnt, line_valid, pix_ready);
        end
        tick();
        pix_valid = 1'b0;
        note_col(0, 8'hA0);
        checks++;
        if (I_out_line[0] !== 8'hA0 || I_out_line[1] !== exp_i[1]) begin
            errors++;
            $display("FAIL handoff_col: got [0]=%h [1]=%h expected a0/%h",
                     I_out_line[0], I_out_line[1], exp_i[1]);
        end
        for (int k = 1; k < LS; k++) push_col(k, 8'h40 + 8'(k));
        checks++;
        if (line_valid !== 1'b1 || I_out_line !== exp_i || T_out_line !== exp_t) begin
            errors++;
            $display("FAIL handoff_line2: got valid=%b I=%h expected 1/%h",
                     line_valid, I_out_line, exp_i);
        end
        do_handoff();
        line_ready = 1'b1;
        repeat (2) tick();
        line_ready = 1'b0;
        checks++;
        if (line_cnt !== 16'd2 || line_valid !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_fill: got cnt=%h valid=%b ready=%b expected 0002/0/1",
                     line_cnt, line_valid, pix_ready);
        end
    endtask

    task automatic test_toggle();
        for (int k = 0; k < LS; k++) begin
            set_col(8'h80 + 8'(k));
            pix_valid = 1'b1;
            tick();
            note_col(k, 8'h80 + 8'(k));
            pix_valid = 1'b0;
            set_col(8'hEE);
            if (k == LS - 2) begin
                checks++;
                if (line_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL toggle_early: got %b expected 0", line_valid);
                end
            end
            if (k == LS - 1) begin
                checks++;
                if (line_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL toggle_latency: got %b expected 1", line_valid);
                end
            end
            tick();
        end
        checks++;
        if (I_out_line !== exp_i || T_out_line !== exp_t) begin
            errors++;
            $display("FAIL toggle_line: got %h expected %h", I_out_line, exp_i);
        end
        do_handoff();
        checks++;
        if (line_cnt !== 16'd3) begin
            errors++;
            $display("FAIL toggle_cnt: got %h expected 0003", line_cnt);
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 7; k++) push_col(k, 8'h20 + 8'(k));
        RST_N = 1'b0;
        #1;
        checks++;
        if (pix_ready !== 1'b0 || line_valid !== 1'b0 || line_cnt !== 16'd0 ||
            I_out_line !== '0) begin
            errors++;
            $display("FAIL midrst_async: got ready=%b valid=%b cnt=%h I=%h expected 0",
                     pix_ready, line_valid, line_cnt, I_out_line);
        end
        tick();
        RST_N = 1'b1;
        tick();
        exp_i = '0;
        exp_t = '0;
        fill_line(8'h30);
        checks++;
        if (line_valid !== 1'b1 || I_out_line !== exp_i || T_out_line !== exp_t ||
            line_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_line: got valid=%b cnt=%h I=%h expected 1/0000/%h",
                     line_valid, line_cnt, I_out_line, exp_i);
        end
        do_handoff();
        checks++;
        if (line_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midrst_cnt: got %h expected 0001", line_cnt);
        end
        fill_line(8'h50);
        line_ready = 1'b1;
        RST_N = 1'b0;
        #1;
        checks++;
        if (line_valid !== 1'b0 || line_cnt !== 16'd0 || T_out_line !== '0) begin
            errors++;
            $display("FAIL holdrst: got valid=%b cnt=%h expected 0/0000",
                     line_valid, line_cnt);
        end
        tick();
        line_ready = 1'b0;
        RST_N = 1'b1;
        tick();
        exp_i = '0;
        exp_t = '0;
    endtask

`ifdef LINE_ASM_PAD_EN
    task automatic test_pad();
        fill_line(8'h60);
        do_handoff();
        for (int k = 0; k < 5; k++) begin
            line_end = (k == 4);
            push_col(k, 8'h70 + 8'(k));
        end
        line_end = 1'b0;
        for (int k = 5; k < LS; k++) begin
            exp_i[k] = '0;
            exp_t[k] = '0;
        end
        checks++;
        if (line_valid !== 1'b1) begin
            errors++;
            $display("FAIL pad_valid: got %b expected 1", line_valid);
        end
        checks++;
        if (I_out_line !== exp_i || T_out_line !== exp_t) begin
            errors++;
            $display("FAIL pad_line: got %h expected %h", I_out_line, exp_i);
        end
        do_handoff();
        for (int k = 0; k < LS; k++) begin
            line_end = (k == LS - 1);
            push_col(k, 8'h90 + 8'(k));
        end
        line_end = 1'b0;
        checks++;
        if (line_valid !== 1'b1 || I_out_line !== exp_i || T_out_line !== exp_t) begin
            errors++;
            $display("FAIL pad_full: got valid=%b I=%h expected 1/%h",
                     line_valid, I_out_line, exp_i);
        end
        do_handoff();
    endtask
`endif

    task automatic test_cnt_wrap();
        dut.cnt_q = 16'hFFFE;
        fill_line(8'hC0);
        do_handoff();
        checks++;
        if (line_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_ffff: got %h expected ffff", line_cnt);
        end
        fill_line(8'hD0);
        do_handoff();
        checks++;
        if (line_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got %h expected 0000", line_cnt);
        end
    endtask

    initial begin
`ifdef LINE_ASM_PAD_EN
        line_end = 1'b0;
`endif
        test_reset();
        test_fill();
        test_handoff();
        test_toggle();
        test_mid_reset();
`ifdef LINE_ASM_PAD_EN
        test_pad();
`endif
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
